// File: rtl/bsg_parity_frame_checker_if.sv
// Word stream in, frame report out, for bsg_parity_frame_checker.
// "slave" is the checker's view; "master" is the producer/consumer side.
interface bsg_parity_frame_checker_if #(
    parameter int width_p       = 16,
    parameter int frame_len_p   = 8,
    parameter int total_width_p = 16
);
    logic                               v_i;
    logic [width_p-1:0]                 data_i;
    logic                               parity_i;
    logic                               ready_o;
    logic                               v_o;
    logic                               frame_err_o;
    logic [$clog2(frame_len_p+1)-1:0]   err_words_o;
    logic                               yumi_i;
    logic [total_width_p-1:0]           err_total_o;

    modport master (
        output v_i, data_i, parity_i, yumi_i,
        input  ready_o, v_o, frame_err_o, err_words_o, err_total_o
    );

    modport slave (
        input  v_i, data_i, parity_i, yumi_i,
        output ready_o, v_o, frame_err_o, err_words_o, err_total_o
    );
endinterface

// File: rtl/bsg_parity_frame_checker.sv
// Re-checks even parity per word, counts bad words per frame and reports each frame over valid/yumi.
// Define BSG_PARITY_FRAME_CHECKER_TOTAL_EN to build the saturating cumulative error counter.
module bsg_parity_frame_checker #(
    parameter int width_p       = 16,
    parameter int frame_len_p   = 8,
    parameter int total_width_p = 16
) (
    input logic                          clk_i,
    input logic                          reset_i,
    bsg_parity_frame_checker_if.slave    link
);
    localparam int cnt_w = $clog2(frame_len_p + 1);

    typedef enum logic {
        eRECV,
        eREPORT
    } state_e;

    state_e state_r, state_n;

    logic [width_p-1:0]       data_w;
    logic                     word_bad;
    logic                     xfer;
    logic                     frame_last;
    logic [cnt_w-1:0]         word_cnt_r;
    logic [cnt_w-1:0]         bad_cnt_r;
    logic [cnt_w-1:0]         bad_cnt_n;
    logic [cnt_w-1:0]         err_words_r;
    logic                     frame_err_r;
    logic [total_width_p-1:0] total_w;

    assign data_w     = link.data_i;
    assign word_bad   = ^{data_w, link.parity_i};
    assign xfer       = link.v_i & (state_r == eRECV);
    assign frame_last = (word_cnt_r == cnt_w'(frame_len_p - 1));
    assign bad_cnt_n  = bad_cnt_r + cnt_w'(word_bad);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= eRECV;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            eRECV:   if (xfer && frame_last) state_n = eREPORT;
            eREPORT: if (link.yumi_i)        state_n = eRECV;
            default: state_n = eRECV;
        endcase
    end

    // ready/valid come from state alone, so no input reaches them combinationally
    always_comb begin
        link.ready_o = 1'b0;
        link.v_o     = 1'b0;
        case (state_r)
            eRECV:   link.ready_o = 1'b1;
            eREPORT: link.v_o     = 1'b1;
            default: begin
                link.ready_o = 1'b0;
                link.v_o     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_cnt_r <= '0;
            bad_cnt_r  <= '0;
        end else if (xfer) begin
            if (frame_last) begin
                word_cnt_r <= '0;
                bad_cnt_r  <= '0;
            end else begin
                word_cnt_r <= word_cnt_r + cnt_w'(1);
                bad_cnt_r  <= bad_cnt_n;
            end
        end
    end

    // Report registers capture the final count including the frame's last word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_words_r <= '0;
            frame_err_r <= 1'b0;
        end else if (xfer && frame_last) begin
            err_words_r <= bad_cnt_n;
            frame_err_r <= (bad_cnt_n != '0);
        end
    end

    assign link.err_words_o = err_words_r;
    assign link.frame_err_o = frame_err_r;

`ifdef BSG_PARITY_FRAME_CHECKER_TOTAL_EN
    logic [total_width_p-1:0] total_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            total_r <= '0;
        else if (xfer && word_bad && (total_r != {total_width_p{1'b1}}))
            total_r <= total_r + total_width_p'(1);
    end

    assign total_w = total_r;
`else
    assign total_w = '0;
`endif

    assign link.err_total_o = total_w;

endmodule

// File: tb/tb_bsg_parity_frame_checker.sv
// Directed bench: two frame_len_p=8 checkers (16-bit and 3-bit totals) share one stream,
// plus a frame_len_p=1 checker driven on its own.
module tb_bsg_parity_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v, parity, yumi;
    logic [15:0] data;
    logic        v1, p1, y1;
    logic [15:0] d1;

    int n_checks = 0;
    int n_fail   = 0;
    int bad_total = 0;
    int bad_total1 = 0;

    bsg_parity_frame_checker_if #(.width_p(16), .frame_len_p(8), .total_width_p(16)) ifa ();
    bsg_parity_frame_checker_if #(.width_p(16), .frame_len_p(8), .total_width_p(3))  ifs ();
    bsg_parity_frame_checker_if #(.width_p(16), .frame_len_p(1), .total_width_p(16)) if1 ();

    assign ifa.v_i = v;  assign ifa.data_i = data; assign ifa.parity_i = parity; assign ifa.yumi_i = yumi;
    assign ifs.v_i = v;  assign ifs.data_i = data; assign ifs.parity_i = parity; assign ifs.yumi_i = yumi;
    assign if1.v_i = v1; assign if1.data_i = d1;   assign if1.parity_i = p1;     assign if1.yumi_i = y1;

    bsg_parity_frame_checker #(.width_p(16), .frame_len_p(8), .total_width_p(16)) dut_a (
        .clk_i(clk), .reset_i(reset), .link(ifa));
    bsg_parity_frame_checker #(.width_p(16), .frame_len_p(8), .total_width_p(3)) dut_s (
        .clk_i(clk), .reset_i(reset), .link(ifs));
    bsg_parity_frame_checker #(.width_p(16), .frame_len_p(1), .total_width_p(16)) dut_1 (
        .clk_i(clk), .reset_i(reset), .link(if1));

    function automatic logic [31:0] exp_total(input int t, input int w);
`ifdef BSG_PARITY_FRAME_CHECKER_TOTAL_EN
        int m;
        m = (1 << w) - 1;
        return (t > m) ? m : t;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic p);
        v = 1'b1; data = d; parity = p;
        tick();
        v = 1'b0;
        if (^{d, p}) bad_total++;
    endtask

    task automatic check_totals(input string tag);
        check_output({tag, ".total_a"}, 32'(ifa.err_total_o), exp_total(bad_total, 16));
        check_output({tag, ".total_s"}, 32'(ifs.err_total_o), exp_total(bad_total, 3));
    endtask

    task automatic check_report(input string tag, input int words);
        check_output({tag, ".v_o"},       32'(ifa.v_o),         32'd1);
        check_output({tag, ".ready_o"},   32'(ifa.ready_o),     32'd0);
        check_output({tag, ".err_words"}, 32'(ifa.err_words_o), 32'(words));
        check_output({tag, ".frame_err"}, 32'(ifa.frame_err_o), 32'(words != 0));
        check_output({tag, ".s_v_o"},     32'(ifs.v_o),         32'd1);
        check_output({tag, ".s_words"},   32'(ifs.err_words_o), 32'(words));
        check_totals(tag);
    endtask

    task automatic take_report(input string tag);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check_output({tag, ".ready_after_yumi"}, 32'(ifa.ready_o), 32'd1);
        check_output({tag, ".v_after_yumi"},     32'(ifa.v_o),     32'd0);
    endtask

    task automatic send_single(input string tag, input logic [15:0] d, input logic p);
        logic bad;
        bad = ^{d, p};
        v1 = 1'b1; d1 = d; p1 = p;
        tick();
        v1 = 1'b0;
        if (bad) bad_total1++;
        check_output({tag, ".v_o"},       32'(if1.v_o),         32'd1);
        check_output({tag, ".ready_o"},   32'(if1.ready_o),     32'd0);
        check_output({tag, ".err_words"}, 32'(if1.err_words_o), 32'(bad));
        check_output({tag, ".frame_err"}, 32'(if1.frame_err_o), 32'(bad));
        check_output({tag, ".total"},     32'(if1.err_total_o), exp_total(bad_total1, 16));
        tick();
        check_output({tag, ".held"},      32'(if1.v_o),         32'd1);
        y1 = 1'b1;
        tick();
        y1 = 1'b0;
        check_output({tag, ".ready_back"}, 32'(if1.ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; v = 1'b0; data = '0; parity = 1'b0; yumi = 1'b0;
        v1 = 1'b0; d1 = '0; p1 = 1'b0; y1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check_output("rst.ready",     32'(ifa.ready_o),     32'd1);
        check_output("rst.v_o",       32'(ifa.v_o),         32'd0);
        check_output("rst.frame_err", 32'(ifa.frame_err_o), 32'd0);
        check_output("rst.err_words", 32'(ifa.err_words_o), 32'd0);
        check_totals("rst");
        check_output("rst.ready1",    32'(if1.ready_o),     32'd1);
        check_output("rst.v1",        32'(if1.v_o),         32'd0);

        // Clean frame
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'h00FF, 1'b0);
            if (i == 6) check_output("clean.v_early", 32'(ifa.v_o), 32'd0);
        end
        check_report("clean", 0);
        take_report("clean");

        // Errored frame: words 2 and 7 bad
        for (int i = 1; i <= 8; i++) begin
            if (i == 2 || i == 7) apply_stimulus(16'h0001, 1'b0);
            else                  apply_stimulus(16'h00FF, 1'b0);
        end
        check_report("errored", 2);

        // Backpressure with a bad word offered the whole time
        v = 1'b1; data = 16'h0001; parity = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("bp.v_o",      32'(ifa.v_o),         32'd1);
            check_output("bp.ready",    32'(ifa.ready_o),     32'd0);
            check_output("bp.words",    32'(ifa.err_words_o), 32'd2);
            check_output("bp.total_a",  32'(ifa.err_total_o), exp_total(bad_total, 16));
        end
        v = 1'b0;
        take_report("bp");

        // Next frame must need a full 8 words
        apply_stimulus(16'h0001, 1'b0);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(16'h0000, 1'b0);
            if (i == 5) check_output("after_bp.v_early", 32'(ifa.v_o), 32'd0);
        end
        check_report("after_bp", 1);
        take_report("after_bp");

        // All-bad frames drive the 3-bit total into saturation
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) apply_stimulus(16'h0001, 1'b0);
            check_report("allbad", 8);
            take_report("allbad");
        end

        // Reset mid-frame, with v_i held during reset
        apply_stimulus(16'h0001, 1'b0);
        check_totals("mid.transfer_time");
        for (int i = 0; i < 4; i++) apply_stimulus(16'h00FF, 1'b0);
        reset = 1'b1; v = 1'b1; data = 16'h0001; parity = 1'b0;
        tick();
        reset = 1'b0; v = 1'b0;
        bad_total = 0;
        check_output("mid.v_o",   32'(ifa.v_o),     32'd0);
        check_output("mid.ready", 32'(ifa.ready_o), 32'd1);
        check_totals("mid.cleared");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'h00FF, 1'b0);
            if (i == 6) check_output("mid.v_early", 32'(ifa.v_o), 32'd0);
        end
        check_report("post_reset", 0);
        take_report("post_reset");

        // frame_len_p=1 with gaps between words
        bad_total1 = 0;
        send_single("f1.w0", 16'h0001, 1'b0);
        send_single("f1.w1", 16'h00FF, 1'b0);
        send_single("f1.w2", 16'h0003, 1'b1);
        send_single("f1.w3", 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bsg_parity_frame_checker.md
# bsg_parity_frame_checker

Streaming parity checker that sits directly downstream of the segmented XOR reduction stage. It accepts words, each with the even-parity bit generated upstream, and re-reduces each word with its parity bit. It counts bad words over fixed-length frames and emits one registered report per frame over a valid/yumi interface. It is the consumer of the reduce stage's parity output in the link-integrity path.

## Interface
Parameters:
- width_p, 16, data word width in bits (>=1)
- frame_len_p, 8, words per frame (>=1)
- total_width_p, 16, width of the cumulative error counter (>=1)

Ports:
- clk_i  input  1  clock; one clock domain, all state on rising edge
- reset_i  input  1  synchronous, active-high reset
- v_i  input  1  input word valid
- data_i  input  width_p  input word
- parity_i  input  1  even-parity bit for data_i from the reduce stage
- ready_o  output  1  block can accept a word this cycle
- v_o  output  1  frame report valid
- frame_err_o  output  1  at least one bad word in the reported frame
- err_words_o  output  $clog2(frame_len_p+1)  count of bad words in the reported frame
- yumi_i  input  1  consumer takes the report this cycle (only legal when v_o=1)
- err_total_o  output  total_width_p  saturating count of bad words since reset

## Operation
- A word is bad when the XOR reduction of {data_i, parity_i} is 1. Word parity is computed combinationally and registered only through the counters.
- Transfer in happens when v_i & ready_o.
- FSM states:
  - eRECV: ready_o=1, v_o=0.
    - On each transfer, word_cnt increments and bad_cnt increments if the word is bad.
    - On the transfer where word_cnt==frame_len_p-1: load report registers with the final bad_cnt (including this word) and go to eREPORT. Clear word_cnt and bad_cnt.
  - eREPORT: ready_o=0, v_o=1.
    - frame_err_o = (err_words_o != 0).
    - Outputs are held stable until yumi_i.
    - On yumi_i, go to eRECV.
- yumi_i while v_o=0 is ignored. v_i while ready_o=0 is ignored; data is not consumed.
- bad_cnt never exceeds frame_len_p, and its width covers that value.
- frame_len_p=1: every transfer is a frame end, so each accepted word produces its own report.
- err_total_o (when compiled in):
  - Increments by 1 on every accepted bad word.
  - Updates in the cycle of the transfer, not at report time.
  - Saturates at 2^total_width_p-1 and never wraps.

## Timing
- Reset values: state=eRECV, ready_o=1 in the first cycle after reset deasserts, v_o=0, frame_err_o=0, err_words_o=0, err_total_o=0, word_cnt=0, bad_cnt=0.
- Reset asserted mid-frame discards the partial frame. Reset asserted in eREPORT drops the pending report. Reset overrides simultaneous v_i or yumi_i.
- Latency: v_o rises in the cycle after the last word of a frame is accepted.
- Throughput:
  - One word per cycle inside a frame.
  - ready_o returns to 1 in the cycle after yumi_i.
  - Minimum frame period is frame_len_p+1 cycles with yumi_i held high.
- There is no combinational path from v_i or yumi_i to ready_o or v_o. ready_o depends on state only.

## Configuration
- BSG_PARITY_FRAME_CHECKER_TOTAL_EN:
  - Defined: the cumulative saturating counter is built and err_total_o is driven as described.
  - Undefined: no counter flops exist and err_total_o is tied to 0.
  - Frame reporting is identical either way.

## Test plan
- Clean frame: frame_len_p=8, 8 back-to-back words with correct parity (e.g. data_i=16'h00FF, parity_i=0) -> v_o=1 one cycle after the 8th transfer; frame_err_o=0, err_words_o=0; ready_o=0 until yumi_i.
- Errored frame: words 2 and 7 sent with flipped parity (data_i=16'h0001, parity_i=0) -> report frame_err_o=1, err_words_o=2; err_total_o=2 with TOTAL_EN, 0 without.
- Backpressure: hold yumi_i=0 for 5 cycles after v_o with v_i=1 continuously -> report stable, no words consumed, ready_o=0. After yumi_i, the next frame starts with word_cnt=0.
- All bad frame plus saturation: total_width_p=3, two frames of 8 bad words -> err_words_o=8 for each report; err_total_o stops at 7.
- Reset mid-frame: accept 5 words including 1 bad, then assert reset_i for 1 cycle -> v_o=0, counters 0. A following clean frame reports err_words_o=0 and err_total_o=0.
- Edge length and gaps: frame_len_p=1 with v_i toggling 1/0 -> one report per accepted word, with err_words_o equal to that word's parity error (0 or 1).
